bp_be_dep_tracker: RTL
======================

// Module: bp_be_dep_tracker
// PURPOSE
//  Tracks dependency status of every instruction in flight between dispatch and final writeback.
//  Sits beside the calculator and feeds the hazard detector.
//  Per-stage records shift in lock-step with the execution pipe: ex1, ex2, iwb, fwb, retire.
//  Also produces pre-reduced in-pipe, mem-in-pipe and serial summaries for the detector.
// PARAMETERS
//  depth_p        5   number of tracked stages; legal range 5..8; index 0 = ex1
//  flush_depth_p  3   stages 0..flush_depth_p-1 are killable by flush_i; legal range 1..depth_p
//  reg_addr_width_p 5 register address width
// PORTS
//  clk_i          in   1   clock
//  reset_i        in   1   synchronous, active-high reset
//  dispatch_v_i   in   1   instruction enters ex1 this cycle (detector dispatch AND issue valid)
//  rd_addr_i      in   5   destination register of the dispatched instruction
//  irf_w_v_i      in   1   dispatched instruction writes the integer RF
//  frf_w_v_i      in   1   dispatched instruction writes the FP RF
//  pipe_sel_i     in   2   0=int/ctl, 1=mul, 2=mem, 3=fp
//  serial_v_i     in   1   dispatched instruction serialises the pipe (csr, fence, trap return)
//  flush_i        in   1   kill all entries in stages 0..flush_depth_p-1
//  dep_status_o   out  depth_p*13  per-stage {serial_v,mem_v,fp_fwb_v,mem_fwb_v,fp_iwb_v,mem_iwb_v,mul_iwb_v,rd_addr[4:0],v}; stage 0 in the LSBs
//  instr_in_pipe_o out 1   OR of v over stages 0..2
//  mem_in_pipe_o  out  1   OR of mem_v over stages 0..2
//  serial_haz_o   out  1   OR of serial_v over stages 0..3
//  inflight_cnt_o out  4   popcount of v over all stages
//  perf_dispatch_o out 32  dispatched-instruction counter (see CONFIGURATION)
//  perf_flush_o   out  32  killed-entry counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all stage records are zero, so every output is 0, including the perf counters.
//  - Every cycle, stage[i] <= stage[i-1] for i=1..depth_p-1, with no stall.
//    - The pipe never stalls after dispatch; the detector holds instructions before ex1.
//    - stage[depth_p-1] contents are discarded each cycle.
//  - Stage 0 load:
//    - If dispatch_v_i: stage[0] <= encoded record.
//    - Otherwise: stage[0] <= 0 (bubble, all bits 0, rd_addr=0).
//  - Record encoding:
//    - v=1; mem_v = (pipe_sel_i==2); serial_v = serial_v_i.
//    - mul_iwb_v = irf_w_v_i & pipe_sel_i==1.
//    - mem_iwb_v = irf_w_v_i & pipe_sel_i==2.
//    - fp_iwb_v = irf_w_v_i & pipe_sel_i==3.
//    - mem_fwb_v = frf_w_v_i & pipe_sel_i==2.
//    - fp_fwb_v = frf_w_v_i & pipe_sel_i==3.
//  - x0 rule: if rd_addr_i==0, all *_iwb_v bits are forced to 0. *_fwb_v bits are kept, because f0 is a real register.
//  - Illegal combination: irf_w_v_i & frf_w_v_i both set. Both writeback sets are recorded unmodified; the bench flags it as an error.
//  - Flush:
//    - When flush_i=1, the records leaving stages 0..flush_depth_p-1 arrive in stages 1..flush_depth_p as all-zero.
//    - A same-cycle dispatch is also dropped, so stage[0] <= 0. Flush wins over dispatch.
//    - Stages at or beyond flush_depth_p shift normally.
//  - Summary outputs (instr_in_pipe_o, mem_in_pipe_o, serial_haz_o, inflight_cnt_o) are combinational from the registered stages.
//    - Latency from dispatch to visibility in stage 0 is 1 cycle.
//  - A reset asserted mid-operation clears all stages on that edge; dispatch and flush in the same cycle are ignored.
// CONFIGURATION
//  BP_BE_DEP_TRACKER_PERF_EN
//   defined: two 32-bit saturating counters.
//    - perf_dispatch_o increments on each accepted, unflushed dispatch.
//    - perf_flush_o adds the number of valid entries killed by flush_i that cycle (0..flush_depth_p+1, counting the dropped dispatch).
//    - Both saturate at 32'hFFFF_FFFF and clear on reset.
//   undefined: both outputs are tied to 32'h0, and no counter flops exist.
// TESTING
//  1. Reset for 2 cycles, then idle -> dep_status_o==0, all summaries 0, inflight_cnt_o==0.
//  2. Dispatch rd=5, irf_w, pipe_sel=2 at t0 ->
//     - stage0 mem_iwb_v=1, mem_v=1 at t1; reaches stage 4 at t5; gone at t6.
//     - mem_in_pipe_o=1 for t1..t3, 0 from t4.
//  3. Dispatch rd=0, irf_w, pipe_sel=1 -> v=1, mul_iwb_v=0, instr_in_pipe_o=1.
//     Dispatch rd=0, frf_w, pipe_sel=3 -> fp_fwb_v=1.
//  4. Dispatch 4 back-to-back, then flush_i with a 5th dispatch ->
//     - next cycle: stages 0..3 empty, stage 4 holds the first instruction.
//     - inflight_cnt_o==1; perf_flush_o==4 (3 killed in-pipe + dropped dispatch) when PERF_EN.
//  5. Dispatch serial_v=1 at t0 -> serial_haz_o=1 for t1..t4, 0 at t5.
//  6. PERF_EN with perf_dispatch_o preloaded to 32'hFFFF_FFFE, then 3 dispatches -> saturates at 32'hFFFF_FFFF.
//     Without PERF_EN -> perf outputs stay 0.

Source files
------------

// File: rtl/bp_be_dep_tracker_if.sv
// Dispatch-side inputs and hazard-summary outputs of the dependency tracker.
// The master modport is the detector/dispatch side. The slave modport is the tracker.
interface bp_be_dep_tracker_if #(
  parameter int depth_p          = 5,
  parameter int reg_addr_width_p = 5
);
  localparam int rec_w = 8 + reg_addr_width_p;

  logic                        dispatch_v_i;
  logic [reg_addr_width_p-1:0] rd_addr_i;
  logic                        irf_w_v_i;
  logic                        frf_w_v_i;
  logic [1:0]                  pipe_sel_i;
  logic                        serial_v_i;
  logic                        flush_i;

  logic [depth_p*rec_w-1:0]    dep_status_o;
  logic                        instr_in_pipe_o;
  logic                        mem_in_pipe_o;
  logic                        serial_haz_o;
  logic [3:0]                  inflight_cnt_o;
  logic [31:0]                 perf_dispatch_o;
  logic [31:0]                 perf_flush_o;

  modport master (
    output dispatch_v_i, rd_addr_i, irf_w_v_i, frf_w_v_i, pipe_sel_i, serial_v_i, flush_i,
    input  dep_status_o, instr_in_pipe_o, mem_in_pipe_o, serial_haz_o, inflight_cnt_o,
           perf_dispatch_o, perf_flush_o
  );

  modport slave (
    input  dispatch_v_i, rd_addr_i, irf_w_v_i, frf_w_v_i, pipe_sel_i, serial_v_i, flush_i,
    output dep_status_o, instr_in_pipe_o, mem_in_pipe_o, serial_haz_o, inflight_cnt_o,
           perf_dispatch_o, perf_flush_o
  );
endinterface

// File: rtl/bp_be_dep_tracker.sv
// Per-stage dependency records for ex1..retire, together with pre-reduced hazard summaries.
// Optional saturating perf counters are enabled by defining BP_BE_DEP_TRACKER_PERF_EN.
module bp_be_dep_tracker_stage #(
  parameter int width_p = 13
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               kill_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);
  always_ff @(posedge clk_i)
    if (reset_i | kill_i) q_o <= '0;
    else                  q_o <= d_i;
endmodule

module bp_be_dep_tracker #(
  parameter int depth_p          = 5,
  parameter int flush_depth_p    = 3,
  parameter int reg_addr_width_p = 5
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bp_be_dep_tracker_if.slave   dep
);
  typedef struct packed {
    logic                        serial_v;
    logic                        mem_v;
    logic                        fp_fwb_v;
    logic                        mem_fwb_v;
    logic                        fp_iwb_v;
    logic                        mem_iwb_v;
    logic                        mul_iwb_v;
    logic [reg_addr_width_p-1:0] rd_addr;
    logic                        v;
  } rec_s;

  localparam int rec_w = $bits(rec_s);

  rec_s                 enc;
  rec_s [depth_p-1:0]   stage_d, stage_q;
  logic [depth_p-1:0]   stage_kill;
  logic [depth_p-1:0]   vld_pipe;
  logic                 iwb_ok;

  // Integer writebacks to x0 are dropped. An f0 target is still a real write.
  always_comb begin
    iwb_ok        = dep.irf_w_v_i & (dep.rd_addr_i != '0);
    enc           = '0;
    enc.v         = 1'b1;
    enc.rd_addr   = dep.rd_addr_i;
    enc.serial_v  = dep.serial_v_i;
    enc.mem_v     = (dep.pipe_sel_i == 2'd2);
    enc.mul_iwb_v = iwb_ok & (dep.pipe_sel_i == 2'd1);
    enc.mem_iwb_v = iwb_ok & (dep.pipe_sel_i == 2'd2);
    enc.fp_iwb_v  = iwb_ok & (dep.pipe_sel_i == 2'd3);
    enc.mem_fwb_v = dep.frf_w_v_i & (dep.pipe_sel_i == 2'd2);
    enc.fp_fwb_v  = dep.frf_w_v_i & (dep.pipe_sel_i == 2'd3);
  end

  // Stage i is cleared when its source stage (i-1) is killable and flush is high.
  // Stage 0 is cleared on a bubble or on a flush.
  always_comb begin
    stage_d       = '0;
    stage_kill    = '0;
    stage_d[0]    = enc;
    stage_kill[0] = dep.flush_i | ~dep.dispatch_v_i;
    for (int i = 1; i < depth_p; i++) begin
      stage_d[i]    = stage_q[i-1];
      stage_kill[i] = dep.flush_i & (i <= flush_depth_p);
    end
  end

  for (genvar i = 0; i < depth_p; i++) begin : g_stage
    bp_be_dep_tracker_stage #(.width_p(rec_w)) u_stage (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .kill_i  (stage_kill[i]),
      .d_i     (stage_d[i]),
      .q_o     (stage_q[i])
    );
  end

  always_comb begin
    dep.instr_in_pipe_o = 1'b0;
    dep.mem_in_pipe_o   = 1'b0;
    dep.serial_haz_o    = 1'b0;
    dep.inflight_cnt_o  = '0;
    vld_pipe            = '0;
    for (int i = 0; i < depth_p; i++) begin
      vld_pipe[i]        = stage_q[i].v;
      dep.inflight_cnt_o = dep.inflight_cnt_o + 4'(stage_q[i].v);
      if (i < 3) begin
        dep.instr_in_pipe_o = dep.instr_in_pipe_o | stage_q[i].v;
        dep.mem_in_pipe_o   = dep.mem_in_pipe_o   | stage_q[i].mem_v;
      end
      if (i < 4) dep.serial_haz_o = dep.serial_haz_o | stage_q[i].serial_v;
    end
  end

  assign dep.dep_status_o = stage_q;

`ifdef BP_BE_DEP_TRACKER_PERF_EN
  logic [31:0] perf_dispatch_q, perf_flush_q;
  logic [3:0]  kill_cnt;
  logic [32:0] flush_sum;

  // The killed count includes the dispatch that was dropped in the same cycle.
  always_comb begin
    kill_cnt = 4'(dep.dispatch_v_i);
    for (int i = 0; i < flush_depth_p; i++) kill_cnt = kill_cnt + 4'(vld_pipe[i]);
    flush_sum = {1'b0, perf_flush_q} + 33'(kill_cnt);
  end

  always_ff @(posedge clk_i)
    if (reset_i) begin
      perf_dispatch_q <= '0;
      perf_flush_q    <= '0;
    end else begin
      if (dep.dispatch_v_i & ~dep.flush_i & (perf_dispatch_q != '1))
        perf_dispatch_q <= perf_dispatch_q + 32'd1;
      if (dep.flush_i)
        perf_flush_q <= flush_sum[32] ? '1 : flush_sum[31:0];
    end

  assign dep.perf_dispatch_o = perf_dispatch_q;
  assign dep.perf_flush_o    = perf_flush_q;
`else
  assign dep.perf_dispatch_o = 32'h0;
  assign dep.perf_flush_o    = 32'h0;
`endif
endmodule
